// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts PATTERN out MSB-first on x,
// repeated repeat_n times with an optional idle gap between repeats.
module seq_pattern_gen #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1011,
  parameter int             GAP     = 0,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic             stop,
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int IW = $clog2(N);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [IW-1:0]    TOP  = IW'(N - 1);
  localparam logic [GW-1:0]    GTOP = GW'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] reps_q, reps_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             x_q, x_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state and next-output logic; outputs describe the coming cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    reps_d  = reps_q;
    gap_d   = gap_q;
    x_d     = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_SEND;
          idx_d   = TOP;
          reps_d  = (repeat_n == '0) ? ONE : repeat_n;
          x_d     = PATTERN[N-1];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_SEND: begin
        if (stop) begin
          state_d = S_IDLE;
          idx_d   = '0;
          reps_d  = '0;
        end else if (idx_q != '0) begin
          idx_d   = idx_q - IW'(1);
          x_d     = PATTERN[idx_d];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else if (reps_q > ONE) begin
          reps_d = reps_q - ONE;
          busy_d = 1'b1;
          if (GAP > 0) begin
            state_d = S_GAP;
            gap_d   = GTOP;
          end else begin
            idx_d   = TOP;
            x_d     = PATTERN[N-1];
            valid_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
          reps_d  = '0;
          done_d  = 1'b1;
        end
      end
      S_GAP: begin
        if (stop) begin
          state_d = S_IDLE;
          idx_d   = '0;
          reps_d  = '0;
          gap_d   = '0;
        end else if (gap_q == '0) begin
          state_d = S_SEND;
          idx_d   = TOP;
          x_d     = PATTERN[N-1];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          gap_d  = gap_q - GW'(1);
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      reps_q  <= '0;
      gap_q   <= '0;
      x_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      reps_q  <= reps_d;
      gap_q   <= gap_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign x     = x_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: a back-to-back instance and a GAP=2
// instance share stimulus and are checked against a burst model.
module tb_seq_pattern_gen;

  localparam logic [3:0] PAT = 4'b1011;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic [7:0] repeat_n;

  logic xa, va, ba, da;
  logic xb, vb, bb, db;

  int checks = 0;
  int errors = 0;

  seq_pattern_gen #(.N(4), .PATTERN(4'b1011), .GAP(0), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .repeat_n(repeat_n),
    .stop(stop), .x(xa), .valid(va), .busy(ba), .done(da)
  );

  seq_pattern_gen #(.N(4), .PATTERN(4'b1011), .GAP(2), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start), .repeat_n(repeat_n),
    .stop(stop), .x(xb), .valid(vb), .busy(bb), .done(db)
  );

  always #5 clk = ~clk;

  // Burst model: position within the burst, computed arithmetically
  bit act [2];
  int pos [2];
  int reps [2];
  int gaps [2] = '{0, 2};

  function automatic int blen(input int r, input int g);
    return 4 * r + g * (r - 1);
  endfunction

  function automatic logic [3:0] exp_out(input bit a, input int p,
                                         input int r, input int g);
    int k;
    if (!a) return 4'b0000;
    if (p == blen(r, g)) return 4'b0001;
    k = p % (4 + g);
    if (k < 4) return {PAT[3-k], 3'b110};
    return 4'b0010;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        act[i] <= 1'b0;
        pos[i] <= 0;
        reps[i] <= 1;
      end else if (!act[i] || pos[i] == blen(reps[i], gaps[i])) begin
        if (start && !stop) begin
          act[i]  <= 1'b1;
          pos[i]  <= 0;
          reps[i] <= (repeat_n == 0) ? 1 : int'(repeat_n);
        end else begin
          act[i] <= 1'b0;
        end
      end else if (stop) begin
        act[i] <= 1'b0;
      end else begin
        pos[i] <= pos[i] + 1;
      end
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    logic [3:0] ea, eb;
    ea = exp_out(act[0], pos[0], reps[0], gaps[0]);
    eb = exp_out(act[1], pos[1], reps[1], gaps[1]);
    checks += 2;
    if ({xa, va, ba, da} !== ea) begin
      errors++;
      $display("FAIL model_a t=%0t got xvbd=%b want %b", $time,
               {xa, va, ba, da}, ea);
    end
    if ({xb, vb, bb, db} !== eb) begin
      errors++;
      $display("FAIL model_b t=%0t got xvbd=%b want %b", $time,
               {xb, vb, bb, db}, eb);
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic pulse_start(input logic [7:0] rn);
    @(negedge clk);
    start    = 1'b1;
    repeat_n = rn;
    @(negedge clk);
    start    = 1'b0;
  endtask

  initial begin
    logic [11:0] bits12;
    logic [9:0]  xs, vs;
    int          cnt, dn, bz, m;

    rst = 1'b1; start = 1'b0; stop = 1'b0; repeat_n = '0;
    repeat (3) @(negedge clk);
    check("reset_a", int'({xa, va, ba, da}), 0);
    check("reset_b", int'({xb, vb, bb, db}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single burst, first bit one cycle after the start edge
    pulse_start(8'd1);
    bits12 = '0; cnt = 0;
    for (int i = 0; i < 4; i++) begin
      bits12 = {bits12[10:0], xa};
      cnt += int'(va);
      @(negedge clk);
    end
    check("t1_bits", int'(bits12[3:0]), 11);
    check("t1_valid", cnt, 4);
    check("t1_done", int'(da), 1);
    check("t1_busy", int'(ba), 0);
    repeat (10) @(negedge clk);

    // 2: three back-to-back repeats
    pulse_start(8'd3);
    bits12 = '0; cnt = 0; dn = 0;
    for (int i = 0; i < 12; i++) begin
      bits12 = {bits12[10:0], xa};
      cnt += int'(va);
      dn  += int'(da);
      @(negedge clk);
    end
    check("t2_bits", int'(bits12), 12'hBBB);
    check("t2_valid", cnt, 12);
    m = 0;
    for (int i = 0; i + 4 <= 12; i += 4)
      if (bits12[11-i -: 4] == PAT) m++;
    check("t2_detect", m, 3);
    for (int i = 0; i < 4; i++) begin
      dn += int'(da);
      @(negedge clk);
    end
    check("t2_done_cnt", dn, 1);
    repeat (20) @(negedge clk);

    // 3: gap of two idle cycles between repeats
    pulse_start(8'd2);
    xs = '0; vs = '0; bz = 0;
    for (int i = 0; i < 10; i++) begin
      xs = {xs[8:0], xb};
      vs = {vs[8:0], vb};
      bz += int'(bb);
      @(negedge clk);
    end
    check("t3_x", int'(xs), 10'b1011001011);
    check("t3_valid", int'(vs), 10'b1111001111);
    check("t3_busy", bz, 10);
    check("t3_done", int'(db), 1);
    repeat (10) @(negedge clk);

    // 4: repeat_n of zero behaves as one
    pulse_start(8'd0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cnt += int'(va);
      @(negedge clk);
    end
    check("t4_valid", cnt, 4);
    check("t4_done", int'(da), 1);
    repeat (10) @(negedge clk);

    // 5a: stop during the second bit
    pulse_start(8'd2);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t5_stop_valid", int'(va), 0);
    check("t5_stop_busy", int'(ba), 0);
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      dn += int'(da) + int'(db);
      @(negedge clk);
    end
    check("t5_stop_nodone", dn, 0);

    // 5b: start while busy is ignored
    pulse_start(8'd2);
    cnt = 0; dn = 0;
    for (int i = 0; i < 12; i++) begin
      start = (i >= 1 && i <= 3);
      cnt += int'(va);
      dn  += int'(da);
      @(negedge clk);
    end
    start = 1'b0;
    check("t5_ign_valid", cnt, 8);
    check("t5_ign_done", dn, 1);
    repeat (15) @(negedge clk);

    // 6: asynchronous reset mid-burst, then a clean burst
    pulse_start(8'd3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_async", int'({xa, va, ba, da, xb, vb, bb, db}), 0);
    @(negedge clk);
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    pulse_start(8'd1);
    bits12 = '0;
    for (int i = 0; i < 4; i++) begin
      bits12 = {bits12[10:0], xa};
      @(negedge clk);
    end
    check("t6_bits", int'(bits12[3:0]), 11);
    check("t6_done", int'(da), 1);
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
